ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: the send side of the keyboard link whose receive side feeds the

---
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       shift_q, shift_d;
    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             clk_prev_q, clk_prev_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             fall;
    logic             timeout;

    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign timeout = ~fall && (cnt_q == TO_LAST);

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_sync_q[1];
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RTS: begin
                clk_oe_d = 1'b0;
                cnt_d    = '0;
                state_d  = SEND;
            end
            default: begin
                // SEND/ACK/WAIT_IDLE share the inter-edge watchdog; it wins over any completion.
                cnt_d = fall ? '0 : cnt_q + 1'b1;
                if (timeout) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else if (state_q == SEND) begin
                    if (fall) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 4'd9) state_d = ACK;
                    end
                end else if (state_q == ACK) begin
                    if (fall) begin
                        data_oe_d = 1'b0;
                        if (data_sync_q[1]) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end
                end else begin
                    if (clk_sync_q[1] && data_sync_q[1]) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = err_q;
    assign tx_ready    = ready_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TO  = 5000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0;

    logic [10:0] bits_v;
    bit          ok_v;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) rts_cnt <= rts_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device samples the data line just before each falling edge; frame bit 0 is the start bit.
    task automatic device_frame(input int nfalls, input bit ack, output logic [10:0] bits, output bit ok);
        int t;
        ok = 1'b1;
        bits = '0;
        t = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            ok = 1'b0;
            return;
        end
        repeat (10) @(negedge clk);
        for (int i = 0; i < nfalls; i++) begin
            bits[i] = ps2_data_in;
            if (i == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(tag, (t < 500), 1);
    endtask

    task automatic acked_frame(input string tag, input logic [7:0] b, input logic [10:0] exp_bits);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b);
        device_frame(11, 1'b1, bits_v, ok_v);
        check({tag, "_started"}, ok_v, 1);
        check({tag, "_bits"}, bits_v, exp_bits);
        wait_not_busy({tag, "_finish"});
        @(negedge clk);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"}, err_cnt - e0, 0);
        check({tag, "_ready"}, tx_ready, 1);
    endtask

    initial begin
        int d0, e0, i0, r0, t, c0, c1;

        // 1. reset
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe_after", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_no_pulse", done_cnt + err_cnt, 0);

        // 2. 0xED: {stop, parity, data, start}
        i0 = inh_cnt;
        r0 = rts_cnt;
        d0 = done_cnt;
        @(negedge clk);
        tx_data  = 8'hED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ed_accept_lat", {ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 4'b1010);
        device_frame(11, 1'b1, bits_v, ok_v);
        check("ed_bits", bits_v, 11'b1_1_11101101_0);
        check("ed_inhibit_len", inh_cnt - i0, INH);
        check("ed_rts_len", rts_cnt - r0, 1);
        wait_not_busy("ed_finish");
        @(negedge clk);
        check("ed_done", done_cnt - d0, 1);
        check("ed_ready", tx_ready, 1);

        // 3. 0x07 (parity 0) with a stray request mid-frame, then 0x00 (parity 1)
        d0 = done_cnt;
        send_byte(8'h07);
        fork
            device_frame(11, 1'b1, bits_v, ok_v);
            begin
                repeat (300) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check("x07_bits", bits_v, 11'b1_0_00000111_0);
        wait_not_busy("x07_finish");
        repeat (200) @(negedge clk);
        check("x07_no_queue", busy, 0);
        check("x07_done", done_cnt - d0, 1);
        acked_frame("x00", 8'h00, 11'b1_1_00000000_0);

        // 4. no ACK
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hF4);
        device_frame(11, 1'b0, bits_v, ok_v);
        check("nak_bits", bits_v, 11'b1_0_11110100_0);
        wait_not_busy("nak_finish");
        @(negedge clk);
        check("nak_err", err_cnt - e0, 1);
        check("nak_done", done_cnt - d0, 0);
        check("nak_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("nak_ready", tx_ready, 1);

        // 5. device silent after RTS
        e0 = err_cnt;
        send_byte(8'hFF);
        t = 0;
        while (!(ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) && t < 300) begin @(negedge clk); t++; end
        while (ps2_clk_oe !== 1'b0 && t < 300) begin @(negedge clk); t++; end
        check("to_reach_send", (t < 300), 1);
        c0 = cyc;
        t = 0;
        while (tx_error !== 1'b1 && t < TO + 500) begin @(negedge clk); t++; end
        c1 = cyc;
        check("to_latency", c1 - c0, TO);
        check("to_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        check("to_err_once", err_cnt - e0, 1);
        check("to_ready", tx_ready, 1);

        // 6. reset after fall 5 of 0xFF
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hFF);
        device_frame(5, 1'b0, bits_v, ok_v);
        check("mid_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_busy", busy, 0);
        reset = 1'b0;
        repeat (TO + 100) @(negedge clk);
        check("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        check("never_both", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
